// File: rtl/r2sdf_butterfly_pkg.sv
// Shared definitions for the R2SDF FFT stages: FSM states and the rounding constant.
package r2sdf_butterfly_pkg;

   typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

   // Half an LSB of the Q1.(tw_width-1) product, added before the right shift.
   function automatic longint round_bias(input int tw_width);
      return longint'(1) << (tw_width - 2);
   endfunction

endpackage

// File: rtl/cmplx_mult_rs.sv
// Combinational complex multiply by a Q1.(TW_WIDTH-1) twiddle, with round-half-up and saturation.
module cmplx_mult_rs
   import r2sdf_butterfly_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int TW_WIDTH = 16
) (
   input  logic signed [WIDTH-1:0]    a_re,
   input  logic signed [WIDTH-1:0]    a_im,
   input  logic signed [TW_WIDTH-1:0] w_re,
   input  logic signed [TW_WIDTH-1:0] w_im,
   output logic signed [WIDTH-1:0]    y_re,
   output logic signed [WIDTH-1:0]    y_im
);

   localparam int PW = WIDTH + TW_WIDTH + 1;
   localparam logic signed [PW-1:0] BIAS    = PW'(round_bias(TW_WIDTH));
   localparam logic signed [PW-1:0] SAT_MAX = PW'((longint'(1) << (WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

   logic signed [PW-1:0] ar, ai, wr, wi;
   logic signed [PW-1:0] acc_re, acc_im, rs_re, rs_im;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
      if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
      if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
      return v[WIDTH-1:0];
   endfunction

   // Sign-extend everything to the full product width so no partial product wraps.
   assign ar = PW'(a_re);
   assign ai = PW'(a_im);
   assign wr = PW'(w_re);
   assign wi = PW'(w_im);

   assign acc_re = ar * wr - ai * wi;
   assign acc_im = ar * wi + ai * wr;

   assign rs_re = (acc_re + BIAS) >>> (TW_WIDTH - 1);
   assign rs_im = (acc_im + BIAS) >>> (TW_WIDTH - 1);

   assign y_re = sat(rs_re);
   assign y_im = sat(rs_im);

endmodule

// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly; the D-deep delay line closing the loop lives one level up.
module r2sdf_butterfly
   import r2sdf_butterfly_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int TW_WIDTH  = 16,
   parameter int STAGE_LOG = 3
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       in_valid,
   input  logic signed [WIDTH-1:0]    in_re,
   input  logic signed [WIDTH-1:0]    in_im,
   input  logic signed [WIDTH-1:0]    fb_re,
   input  logic signed [WIDTH-1:0]    fb_im,
   output logic signed [WIDTH-1:0]    dl_re,
   output logic signed [WIDTH-1:0]    dl_im,
   output logic [STAGE_LOG-1:0]       tw_addr,
   input  logic signed [TW_WIDTH-1:0] tw_re,
   input  logic signed [TW_WIDTH-1:0] tw_im,
   output logic                       out_valid,
   output logic signed [WIDTH-1:0]    out_re,
   output logic signed [WIDTH-1:0]    out_im,
   output logic                       out_last,
   output logic                       frame_err
);

   localparam int W1 = WIDTH + 1;
   localparam logic [STAGE_LOG-1:0] C_LAST = STAGE_LOG'((1 << STAGE_LOG) - 1);
   localparam logic [STAGE_LOG-1:0] C_ONE  = STAGE_LOG'(1);

   state_t               state_reg, state_next;
   logic [STAGE_LOG-1:0] c_reg, c_next;
   logic                 pend_reg, pend_next;

   logic                    res_valid, res_last, res_err, use_mult;
   logic signed [WIDTH-1:0] res_re, res_im, mul_re, mul_im;
   logic signed [WIDTH-1:0] half_sum_re, half_sum_im, half_dif_re, half_dif_im;
   logic signed [W1-1:0]    sum_re, sum_im, dif_re, dif_im;

   // One extra bit keeps a+b and a-b exact before halving.
   assign sum_re = W1'(fb_re) + W1'(in_re);
   assign sum_im = W1'(fb_im) + W1'(in_im);
   assign dif_re = W1'(fb_re) - W1'(in_re);
   assign dif_im = W1'(fb_im) - W1'(in_im);

   assign half_sum_re = WIDTH'(sum_re >>> 1);
   assign half_sum_im = WIDTH'(sum_im >>> 1);
   assign half_dif_re = WIDTH'(dif_re >>> 1);
   assign half_dif_im = WIDTH'(dif_im >>> 1);

   cmplx_mult_rs #(
      .WIDTH    (WIDTH),
      .TW_WIDTH (TW_WIDTH)
   ) u_mult (
      .a_re (fb_re),
      .a_im (fb_im),
      .w_re (tw_re),
      .w_im (tw_im),
      .y_re (mul_re),
      .y_im (mul_im)
   );

   always_comb begin
      state_next = state_reg;
      c_next     = c_reg;
      pend_next  = pend_reg;
      dl_re      = '0;
      dl_im      = '0;
      tw_addr    = '0;
      use_mult   = 1'b0;
      res_valid  = 1'b0;
      res_last   = 1'b0;
      res_err    = 1'b0;

      case (state_reg)
         IDLE: begin
            pend_next = 1'b0;
            if (in_valid) begin
               dl_re      = in_re;
               dl_im      = in_im;
               state_next = FILL;
               c_next     = C_ONE;
            end
         end
         FILL: begin
            tw_addr = c_reg;
            if (!in_valid) begin
               res_err    = 1'b1;
               state_next = IDLE;
               c_next     = '0;
               pend_next  = 1'b0;
            end else begin
               dl_re     = in_re;
               dl_im     = in_im;
               use_mult  = pend_reg;
               res_valid = pend_reg;
               res_last  = pend_reg && (c_reg == C_LAST);
               c_next    = c_reg + C_ONE;
               if (c_reg == C_LAST) begin
                  pend_next  = 1'b0;
                  state_next = BFLY;
               end
            end
         end
         BFLY: begin
            if (!in_valid) begin
               res_err    = 1'b1;
               state_next = IDLE;
               c_next     = '0;
               pend_next  = 1'b0;
            end else begin
               dl_re     = half_dif_re;
               dl_im     = half_dif_im;
               res_valid = 1'b1;
               c_next    = c_reg + C_ONE;
               if (c_reg == C_LAST) begin
                  pend_next  = 1'b1;
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            tw_addr   = c_reg;
            use_mult  = 1'b1;
            res_valid = 1'b1;
            // A new frame may only start at index 0 so its FILL lines up with the pending differences.
            if (in_valid && c_reg == '0) begin
               dl_re      = in_re;
               dl_im      = in_im;
               state_next = FILL;
               c_next     = C_ONE;
            end else begin
               res_err = in_valid;
               c_next  = c_reg + C_ONE;
               if (c_reg == C_LAST) begin
                  res_last   = 1'b1;
                  pend_next  = 1'b0;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            c_next     = '0;
            pend_next  = 1'b0;
         end
      endcase

      res_re = use_mult ? mul_re : half_sum_re;
      res_im = use_mult ? mul_im : half_sum_im;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= IDLE;
         c_reg     <= '0;
         pend_reg  <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_reg <= state_next;
         c_reg     <= c_next;
         pend_reg  <= pend_next;
         out_valid <= res_valid;
         out_re    <= res_valid ? res_re : '0;
         out_im    <= res_valid ? res_im : '0;
         out_last  <= res_last;
         frame_err <= res_err;
      end
   end

endmodule
